rs_syndrome_rx: RTL and testbench
=================================

RS_SYNDROME_RX -- requirements
Module: rs_syndrome_rx

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 resetN  input  1  asynchronous, active-low reset; synchronous release.
REQ-003 symbolIn  input  4  received GF(16) symbol, polynomial basis, primitive poly x^4+x+1.
REQ-004 symbolValid  input  1  symbolIn carries a valid symbol this cycle.
REQ-005 symbolReady  output  1  block accepts a symbol this cycle; transfer = symbolValid & symbolReady.
REQ-006 syndromeAck  input  1  consumer has taken the result; releases DONE.
REQ-007 syndromeOut  output  24  S1..S6 packed, S_j at bits [4*(j-1) +: 4].
REQ-008 recievedWordOut  output  60  captured RS(15,9) word, coefficient of x^i at bits [4*i +: 4].
REQ-009 syndromeValid  output  1  syndromeOut, recievedWordOut, errorDetected are final.
REQ-010 errorDetected  output  1  OR of all syndrome bits, qualified by syndromeValid.
REQ-011 rxBusy  output  1  frame in progress or result pending.
REQ-012 symbolCount  output  4  symbols accepted in current frame, 0..15.

Function
REQ-013 Frame = 15 symbols, highest-degree coefficient first: first accepted symbol is r14, last is r0.
REQ-014 States IDLE, COLLECT, DONE; IDLE->COLLECT on first transfer; COLLECT->DONE on 15th transfer; DONE->IDLE on cycle syndromeAck=1.
REQ-015 symbolReady = 1 in IDLE and COLLECT, 0 in DONE; symbolValid in DONE is ignored, no state change.
REQ-016 Per transfer, each S_j (j=1..6) updates by Horner: S_j <= (S_j * alpha^j) XOR symbolIn, constant multipliers combinational, 4-bit GF arithmetic only (no carries).
REQ-017 First transfer of a frame uses S_j = 0 as prior value, so S_j <= symbolIn for all j.
REQ-018 Per transfer, symbol stored at recievedWordOut[4*(14-symbolCount) +: 4]; symbolCount increments.
REQ-019 Syndromes final in the cycle after the 15th transfer; latency last-symbol-to-syndromeValid = 1 clock.
REQ-020 syndromeValid = 1 only in DONE; syndromeOut and recievedWordOut held stable throughout DONE.
REQ-021 errorDetected = 1 iff any S_j nonzero, forced 0 outside DONE.
REQ-022 rxBusy = 1 in COLLECT and DONE, 0 in IDLE.
REQ-023 On DONE->IDLE: symbolCount, S_j cleared to 0; recievedWordOut retains last word until overwritten.
REQ-024 syndromeAck outside DONE is ignored.
REQ-025 symbolValid gaps within COLLECT are allowed; state, count, syndromes hold.
REQ-026 symbolCount wraps 15->0 only via DONE->IDLE; never exceeds 15.
REQ-027 syndromeAck and symbolValid in same DONE cycle: leave DONE, symbol not accepted (symbolReady was 0).

Reset
REQ-028 resetN low asynchronously forces IDLE, S_j=0, symbolCount=0, recievedWordOut=0, syndromeValid=0, errorDetected=0, rxBusy=0, symbolReady=0 while asserted.
REQ-029 Reset mid-frame discards partial frame; first transfer after release starts a new frame at r14.
REQ-030 symbolReady = 1 on first clock edge after resetN release.

Verification
REQ-031 15 zero symbols, no gaps -> syndromeValid one cycle after 15th, syndromeOut=0x000000, errorDetected=0, recievedWordOut=0.
REQ-032 14 zeros then 0x1 (error e=1 at x^0) -> syndromeOut=0x111111, errorDetected=1, recievedWordOut=0x...001.
REQ-033 13 zeros, 0x1, 0x0 (error at x^1) -> syndromeOut=0xC63842, recievedWordOut bits[7:4]=0x1.
REQ-034 REQ-033 frame with symbolValid low 3 cycles after symbol 5 -> identical syndromeOut; symbolCount holds 5 during gap.
REQ-035 Hold syndromeAck=0 for 10 cycles in DONE while driving symbolValid=1 -> outputs stable, symbolReady=0; ack -> IDLE, rxBusy=0, symbolCount=0.
REQ-036 Assert resetN low after 7 symbols, release, send REQ-032 frame -> syndromeOut=0x111111 (no residue from aborted frame).

Source files
------------

// File: rtl/rs_syndrome_rx.sv
// -----------------------------------------------------------------------------
// rs_syndrome_rx
// Receive side of an RS(15,9) code over GF(16) (primitive polynomial
// x^4 + x + 1). Accepts one 15-symbol frame, highest-degree coefficient first
// (r14 .. r0), evaluates the six syndromes S_j = r(alpha^j), j = 1..6, on the
// fly with Horner's rule, and holds the result together with the captured
// word until the consumer acknowledges it.
//
// Ports
//   clk             in   1   system clock, rising edge
//   resetN          in   1   asynchronous active-low reset (release is
//                            expected to be synchronous to clk)
//   symbolIn        in   4   received GF(16) symbol, polynomial basis
//   symbolValid     in   1   symbolIn is valid this cycle
//   symbolReady     out  1   block accepts a symbol this cycle
//   syndromeAck     in   1   consumer has taken the result (DONE -> IDLE)
//   syndromeOut     out 24   S1..S6, S_j at bits [4*(j-1) +: 4]
//   recievedWordOut out 60   captured word, coefficient of x^i at [4*i +: 4]
//   syndromeValid   out  1   result outputs are final (DONE state)
//   errorDetected   out  1   any syndrome bit set, only while syndromeValid
//   rxBusy          out  1   frame in progress or result pending
//   symbolCount     out  4   symbols accepted in the current frame
//
// Every output is a register; the next-state values are computed
// combinationally from the current state and the incoming symbol so that
// the result flags are valid in the first DONE cycle.
// -----------------------------------------------------------------------------
module rs_syndrome_rx (
    input  logic        clk,
    input  logic        resetN,
    input  logic [3:0]  symbolIn,
    input  logic        symbolValid,
    output logic        symbolReady,
    input  logic        syndromeAck,
    output logic [23:0] syndromeOut,
    output logic [59:0] recievedWordOut,
    output logic        syndromeValid,
    output logic        errorDetected,
    output logic        rxBusy,
    output logic [3:0]  symbolCount
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [3:0] LAST_INDEX = 4'd14;   // count value of the 15th symbol

    state_t      state_r;
    logic        transfer_s;
    logic [3:0]  slot_s;
    logic [23:0] synd_next_s;
    logic [59:0] word_next_s;
    logic        synd_nonzero_s;

    // -------------------------------------------------------------------------
    // GF(16) helpers
    // -------------------------------------------------------------------------

    // Multiply by alpha: shift up one degree and fold x^4 back as x + 1.
    function automatic logic [3:0] gf_mul_alpha(input logic [3:0] a);
        logic [3:0] r;
        r = {a[2:0], 1'b0};
        if (a[3]) begin
            r = r ^ 4'b0011;
        end else begin
            r = r;
        end
        return r;
    endfunction

    // Multiply by alpha^n for a constant n in 0..6; unrolls to pure XOR logic.
    function automatic logic [3:0] gf_mul_alpha_pow(input logic [3:0] a,
                                                    input int         n);
        logic [3:0] r;
        r = a;
        for (int k = 0; k < 6; k++) begin
            if (k < n) begin
                r = gf_mul_alpha(r);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // symbolReady is registered, so it already reflects the current state.
    assign transfer_s = symbolValid & symbolReady;

    // Word slot for the incoming symbol: the k-th accepted symbol is r(14-k).
    always_comb begin
        slot_s = LAST_INDEX;
        if (state_r == ST_IDLE) begin
            slot_s = LAST_INDEX;
        end else begin
            slot_s = LAST_INDEX - symbolCount;
        end
    end

    // Horner step for all six syndromes; the first symbol of a frame sees a zero prior.
    always_comb begin
        synd_next_s = 24'd0;
        for (int j = 1; j <= 6; j++) begin
            if (state_r == ST_IDLE) begin
                synd_next_s[4*(j-1) +: 4] = symbolIn;
            end else begin
                synd_next_s[4*(j-1) +: 4] =
                    gf_mul_alpha_pow(syndromeOut[4*(j-1) +: 4], j) ^ symbolIn;
            end
        end
    end

    // Captured word with the incoming symbol written into its slot.
    always_comb begin
        word_next_s = recievedWordOut;
        word_next_s[{slot_s, 2'b00} +: 4] = symbolIn;
    end

    // Error flag of the result being completed this cycle.
    assign synd_nonzero_s = |synd_next_s;

    // Frame FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r         <= ST_IDLE;
            syndromeOut     <= 24'd0;
            recievedWordOut <= 60'd0;
            symbolCount     <= 4'd0;
            symbolReady     <= 1'b0;
            syndromeValid   <= 1'b0;
            errorDetected   <= 1'b0;
            rxBusy          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    symbolReady   <= 1'b1;
                    syndromeValid <= 1'b0;
                    errorDetected <= 1'b0;
                    if (transfer_s) begin
                        state_r         <= ST_COLLECT;
                        syndromeOut     <= synd_next_s;
                        recievedWordOut <= word_next_s;
                        symbolCount     <= 4'd1;
                        rxBusy          <= 1'b1;
                    end else begin
                        rxBusy          <= 1'b0;
                    end
                end

                ST_COLLECT: begin
                    rxBusy <= 1'b1;
                    if (transfer_s) begin
                        syndromeOut     <= synd_next_s;
                        recievedWordOut <= word_next_s;
                        symbolCount     <= symbolCount + 4'd1;
                        if (symbolCount == LAST_INDEX) begin
                            // 15th symbol: result is final on the next cycle.
                            state_r       <= ST_DONE;
                            symbolReady   <= 1'b0;
                            syndromeValid <= 1'b1;
                            errorDetected <= synd_nonzero_s;
                        end else begin
                            symbolReady   <= 1'b1;
                            syndromeValid <= 1'b0;
                            errorDetected <= 1'b0;
                        end
                    end else begin
                        // Gap in the stream: everything holds.
                        symbolReady   <= 1'b1;
                        syndromeValid <= 1'b0;
                        errorDetected <= 1'b0;
                    end
                end

                ST_DONE: begin
                    // Incoming symbols are refused here (symbolReady is 0).
                    if (syndromeAck) begin
                        state_r       <= ST_IDLE;
                        syndromeOut   <= 24'd0;
                        symbolCount   <= 4'd0;
                        symbolReady   <= 1'b1;
                        syndromeValid <= 1'b0;
                        errorDetected <= 1'b0;
                        rxBusy        <= 1'b0;
                    end else begin
                        symbolReady   <= 1'b0;
                        syndromeValid <= 1'b1;
                        rxBusy        <= 1'b1;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean IDLE.
                    state_r       <= ST_IDLE;
                    syndromeOut   <= 24'd0;
                    symbolCount   <= 4'd0;
                    symbolReady   <= 1'b1;
                    syndromeValid <= 1'b0;
                    errorDetected <= 1'b0;
                    rxBusy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_syndrome_rx.sv
// -----------------------------------------------------------------------------
// tb_rs_syndrome_rx
// Scoreboard bench: the stimulus process pushes the expected result of every
// frame it sends; a monitor pops and compares on the first cycle of each
// syndromeValid pulse. The reference model evaluates r(alpha^j) directly as a
// sum of products using exp/log tables of GF(16).
// -----------------------------------------------------------------------------
module tb_rs_syndrome_rx;

    logic        clk = 1'b0;
    logic        resetN;
    logic [3:0]  symbolIn;
    logic        symbolValid;
    logic        symbolReady;
    logic        syndromeAck;
    logic [23:0] syndromeOut;
    logic [59:0] recievedWordOut;
    logic        syndromeValid;
    logic        errorDetected;
    logic        rxBusy;
    logic [3:0]  symbolCount;

    typedef struct {
        logic [23:0] synd;
        logic [59:0] word;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   gf_exp[15];
    int   gf_log[16];
    logic prev_valid = 1'b0;

    rs_syndrome_rx dut (
        .clk             (clk),
        .resetN          (resetN),
        .symbolIn        (symbolIn),
        .symbolValid     (symbolValid),
        .symbolReady     (symbolReady),
        .syndromeAck     (syndromeAck),
        .syndromeOut     (syndromeOut),
        .recievedWordOut (recievedWordOut),
        .syndromeValid   (syndromeValid),
        .errorDetected   (errorDetected),
        .rxBusy          (rxBusy),
        .symbolCount     (symbolCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic init_tables();
        int a;
        a = 1;
        for (int k = 0; k < 15; k++) begin
            gf_exp[k] = a;
            gf_log[a] = k;
            a = a << 1;
            if ((a & 16) != 0) a = a ^ 19;   // reduce by x^4 + x + 1
        end
        gf_log[0] = 0;
    endtask

    function automatic int gf_mul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gf_exp[(gf_log[a] + gf_log[b]) % 15];
    endfunction

    // S_j = sum over i of r_i * alpha^(i*j)
    function automatic logic [23:0] model_synd(input logic [59:0] w);
        logic [23:0] res;
        int s;
        res = 24'd0;
        for (int j = 1; j <= 6; j++) begin
            s = 0;
            for (int i = 0; i < 15; i++)
                s = s ^ gf_mul(int'(w[4*i +: 4]), gf_exp[(i * j) % 15]);
            res[4*(j-1) +: 4] = s[3:0];
        end
        return res;
    endfunction

    task automatic push_exp(input logic [23:0] s, input logic [59:0] w);
        exp_t e;
        e.synd = s;
        e.word = w;
        e.err  = (s != 24'd0);
        sb_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (resetN === 1'b1 && syndromeValid === 1'b1 && prev_valid === 1'b0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: result with empty scoreboard synd=%0h", syndromeOut);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_syndrome", 64'(syndromeOut), 64'(mon_e.synd));
                chk("sb_word", 64'(recievedWordOut), 64'(mon_e.word));
                chk("sb_error", 64'(errorDetected), 64'(mon_e.err));
            end
        end
        if (resetN === 1'b1 && syndromeValid !== 1'b1)
            chk("err_outside_done", 64'(errorDetected), 64'd0);
        prev_valid <= syndromeValid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_sym(input logic [3:0] s);
        int n;
        n = 0;
        symbolIn    = s;
        symbolValid = 1'b1;
        while (symbolReady !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'(symbolReady), 64'd1);
        @(posedge clk); #1;
        symbolValid = 1'b0;
    endtask

    task automatic send_frame(input logic [59:0] w, input int gap_after,
                              input int gap_len, input bit rnd_gaps);
        int n;
        for (int k = 0; k < 15; k++) begin
            send_sym(w[4*(14-k) +: 4]);
            if (k == gap_after - 1) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge clk); #1;
                    chk("gap_count_hold", 64'(symbolCount), 64'(gap_after));
                end
            end else if (rnd_gaps && k < 14 && $urandom_range(0, 3) == 0) begin
                n = $urandom_range(1, 3);
                syndromeAck = 1'($urandom_range(0, 1));   // ignored while collecting
                symbolIn    = 4'($urandom);
                repeat (n) begin @(posedge clk); #1; end
                syndromeAck = 1'b0;
                chk("rand_gap_count", 64'(symbolCount), 64'(k + 1));
                chk("rand_gap_busy", 64'(rxBusy), 64'd1);
            end
        end
        chk("latency_valid", 64'(syndromeValid), 64'd1);
        chk("done_ready", 64'(symbolReady), 64'd0);
        chk("done_count", 64'(symbolCount), 64'd15);
        chk("done_busy", 64'(rxBusy), 64'd1);
    endtask

    task automatic wait_and_ack(input int hold);
        int n;
        n = 0;
        while (syndromeValid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("done_timeout", 64'(syndromeValid), 64'd1);
        repeat (hold) begin @(posedge clk); #1; end
        syndromeAck = 1'b1;
        @(posedge clk); #1;
        syndromeAck = 1'b0;
        chk("ack_idle_busy", 64'(rxBusy), 64'd0);
        chk("ack_idle_count", 64'(symbolCount), 64'd0);
        chk("ack_idle_ready", 64'(symbolReady), 64'd1);
        chk("ack_idle_valid", 64'(syndromeValid), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [59:0] w;
        init_tables();
        resetN      = 1'b0;
        symbolValid = 1'b0;
        syndromeAck = 1'b0;
        symbolIn    = 4'd0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_ready", 64'(symbolReady), 64'd0);
        chk("rst_valid", 64'(syndromeValid), 64'd0);
        chk("rst_busy", 64'(rxBusy), 64'd0);
        chk("rst_count", 64'(symbolCount), 64'd0);
        chk("rst_synd", 64'(syndromeOut), 64'd0);
        chk("rst_word", 64'(recievedWordOut), 64'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk); #1;
        chk("release_ready", 64'(symbolReady), 64'd1);
        chk("release_busy", 64'(rxBusy), 64'd0);

        // All-zero frame
        push_exp(24'h000000, 60'h0);
        send_frame(60'h0, 0, 0, 1'b0);
        wait_and_ack(0);

        // Single error at x^0
        push_exp(24'h111111, 60'h1);
        send_frame(60'h1, 0, 0, 1'b0);
        wait_and_ack(1);

        // Single error at x^1
        push_exp(24'hC63842, 60'h10);
        send_frame(60'h10, 0, 0, 1'b0);
        wait_and_ack(0);

        // Same frame with a 3-cycle gap after the fifth symbol
        push_exp(24'hC63842, 60'h10);
        send_frame(60'h10, 5, 3, 1'b0);
        wait_and_ack(2);

        // Long DONE hold with symbolValid asserted, then ack together with valid
        push_exp(24'h111111, 60'h1);
        send_frame(60'h1, 0, 0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            symbolValid = 1'b1;
            symbolIn    = 4'($urandom);
            @(posedge clk); #1;
            chk("hold_synd", 64'(syndromeOut), 64'h111111);
            chk("hold_word", 64'(recievedWordOut), 64'h1);
            chk("hold_ready", 64'(symbolReady), 64'd0);
            chk("hold_count", 64'(symbolCount), 64'd15);
            chk("hold_valid", 64'(syndromeValid), 64'd1);
        end
        syndromeAck = 1'b1;
        @(posedge clk); #1;
        symbolValid = 1'b0;
        syndromeAck = 1'b0;
        chk("ackv_count", 64'(symbolCount), 64'd0);
        chk("ackv_busy", 64'(rxBusy), 64'd0);
        chk("ackv_ready", 64'(symbolReady), 64'd1);
        chk("ackv_synd_clear", 64'(syndromeOut), 64'd0);
        chk("ackv_word_kept", 64'(recievedWordOut), 64'h1);

        // Reset in the middle of a frame, then a clean frame
        for (int k = 0; k < 7; k++) send_sym(4'($urandom_range(1, 15)));
        #2;
        resetN = 1'b0;
        #1;
        chk("async_rst_ready", 64'(symbolReady), 64'd0);
        chk("async_rst_count", 64'(symbolCount), 64'd0);
        chk("async_rst_busy", 64'(rxBusy), 64'd0);
        chk("async_rst_synd", 64'(syndromeOut), 64'd0);
        chk("async_rst_word", 64'(recievedWordOut), 64'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk); #1;
        chk("rerelease_ready", 64'(symbolReady), 64'd1);
        push_exp(24'h111111, 60'h1);
        send_frame(60'h1, 0, 0, 1'b0);
        wait_and_ack(0);

        // Random frames checked against the reference model
        for (int f = 0; f < 10; f++) begin
            w = {28'($urandom), 32'($urandom)};
            push_exp(model_synd(w), w);
            send_frame(w, 0, 0, 1'b1);
            wait_and_ack($urandom_range(0, 3));
        end

        repeat (3) begin @(posedge clk); #1; end
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on simulation time
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
